// File: rtl/runner_game_core_if.sv
// Bundle between the runner playfield engine and its keypad/LFSR inputs and display consumers.
// master drives the control pulses and randomness; slave is the game core.
interface runner_game_core_if #(
    parameter int unsigned COLS    = 16,
    parameter int unsigned SCORE_W = 16
);
    logic               start;
    logic               jump;
    logic               pause;
    logic [7:0]         rand_in;
    logic [1:0]         state;
    logic [COLS-1:0]    obstacle_map;
    logic               dino_air;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic               step_pulse;
    logic [31:0]        period_cur;

    modport master (
        output start, jump, pause, rand_in,
        input  state, obstacle_map, dino_air, score, high_score, step_pulse, period_cur
    );

    modport slave (
        input  start, jump, pause, rand_in,
        output state, obstacle_map, dino_air, score, high_score, step_pulse, period_cur
    );
endinterface

// File: rtl/runner_game_core.sv
// Side-scrolling runner playfield engine: game FSM, variable-rate scroll timer, obstacle
// spawn/shift, jump timing, collision, score with speed-up, pause and session high score.
module runner_game_core #(
    parameter int unsigned COLS          = 16,
    parameter int unsigned TICK_INIT     = 250000,
    parameter int unsigned TICK_MIN      = 62500,
    parameter int unsigned TICK_DEC      = 12500,
    parameter int unsigned SPEEDUP_EVERY = 10,
    parameter int unsigned JUMP_STEPS    = 3,
    parameter int unsigned MIN_GAP       = 2,
    parameter int unsigned SCORE_W       = 16
) (
    input logic               CLK,
    input logic               RST,
    runner_game_core_if.slave bus
);
    localparam int unsigned GapW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam int unsigned AirW = (JUMP_STEPS > 0) ? $clog2(JUMP_STEPS + 1) : 1;

    localparam logic [GapW-1:0]    GapMax     = GapW'(MIN_GAP);
    localparam logic [AirW-1:0]    AirLoad    = AirW'(JUMP_STEPS);
    localparam logic [31:0]        PeriodInit = 32'(TICK_INIT);
    localparam logic [31:0]        PeriodMin  = 32'(TICK_MIN);
    localparam logic [31:0]        PeriodDec  = 32'(TICK_DEC);
    localparam logic [SCORE_W-1:0] SpeedEvery = SCORE_W'(SPEEDUP_EVERY);

    typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StPaused = 2'd2, StOver = 2'd3} state_e;

    state_e             state_q, state_d;
    logic [COLS-1:0]    map_q, map_d, map_next;
    logic [SCORE_W-1:0] score_q, score_d, high_q, high_d, score_inc;
    logic [AirW-1:0]    air_q, air_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic [31:0]        tick_q, tick_d, period_q, period_d;
    logic               step, new_col, airborne;
    logic               unused_rand;

    assign unused_rand = ^bus.rand_in[7:3];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            map_q    <= '0;
            score_q  <= '0;
            high_q   <= '0;
            air_q    <= '0;
            gap_q    <= GapMax;
            tick_q   <= '0;
            period_q <= PeriodInit;
        end else begin
            state_q  <= state_d;
            map_q    <= map_d;
            score_q  <= score_d;
            high_q   <= high_d;
            air_q    <= air_d;
            gap_q    <= gap_d;
            tick_q   <= tick_d;
            period_q <= period_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        map_d     = map_q;
        score_d   = score_q;
        high_d    = high_q;
        air_d     = air_q;
        gap_d     = gap_q;
        tick_d    = tick_q;
        period_d  = period_q;
        step      = 1'b0;
        new_col   = 1'b0;
        airborne  = 1'b0;
        map_next  = '0;
        score_inc = '0;

        unique case (state_q)
            StIdle, StOver: begin
                if (bus.start) begin
                    state_d  = StRun;
                    map_d    = '0;
                    score_d  = '0;
                    air_d    = '0;
                    tick_d   = '0;
                    gap_d    = GapMax;
                    period_d = PeriodInit;
                end
            end
            StPaused: begin
                if (bus.pause) state_d = StRun;
            end
            StRun: begin
                step   = (tick_q == period_q - 32'd1);
                tick_d = step ? '0 : tick_q + 32'd1;
                if (bus.pause) state_d = StPaused;
                if (step) begin
                    new_col  = (bus.rand_in[2:0] == 3'd0) && (gap_q >= GapMax);
                    map_next = {new_col, map_q[COLS-1:1]};
                    map_d    = map_next;
                    if (new_col) gap_d = '0;
                    else if (gap_q != GapMax) gap_d = gap_q + GapW'(1);
                    airborne = (air_q != '0);
                    if (airborne) air_d = air_q - AirW'(1);
                    // A collision overrides a same-cycle pause and freezes the score.
                    if (map_next[0] && !airborne) begin
                        state_d = StOver;
                        if (score_q > high_q) high_d = score_q;
                    end else begin
                        score_inc = (&score_q) ? score_q : score_q + SCORE_W'(1);
                        score_d   = score_inc;
                        if (score_inc != '0 && (score_inc % SpeedEvery) == '0) begin
                            period_d = (period_q >= PeriodMin + PeriodDec) ?
                                       period_q - PeriodDec : PeriodMin;
                        end
                    end
                end
                // Load after the step so the step sees the pre-jump air count.
                if (bus.jump && !bus.pause && air_q == '0) air_d = AirLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.state        = state_q;
    assign bus.obstacle_map = map_q;
    assign bus.dino_air     = (air_q != '0);
    assign bus.score        = score_q;
    assign bus.high_score   = high_q;
    assign bus.step_pulse   = step;
    assign bus.period_cur   = period_q;
endmodule

// File: tb/tb_runner_game_core.sv
// Directed bench for runner_game_core on a small 8-column, fast-tick configuration.
module tb_runner_game_core;
    logic CLK = 1'b0;
    logic RST;
    int   tests = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;

    runner_game_core_if #(.COLS(8), .SCORE_W(16)) bus ();

    runner_game_core #(
        .COLS(8), .TICK_INIT(4), .TICK_MIN(2), .TICK_DEC(1), .SPEEDUP_EVERY(2),
        .JUMP_STEPS(2), .MIN_GAP(2), .SCORE_W(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count clocks until step_pulse is seen, bounded.
    task automatic wait_pulse(output int n);
        n = 0;
        while (bus.step_pulse !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check("step_pulse_seen", 32'(bus.step_pulse), 32'd1);
    endtask

    task automatic step();
        int n;
        wait_pulse(n);
        tick();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_pause();
        bus.pause = 1'b1;
        tick();
        bus.pause = 1'b0;
    endtask

    task automatic pulse_jump();
        bus.jump = 1'b1;
        tick();
        bus.jump = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"}, 32'(bus.state), 32'd0);
        check({tag, "_map"}, 32'(bus.obstacle_map), 32'd0);
        check({tag, "_air"}, 32'(bus.dino_air), 32'd0);
        check({tag, "_score"}, 32'(bus.score), 32'd0);
        check({tag, "_high"}, 32'(bus.high_score), 32'd0);
        check({tag, "_step"}, 32'(bus.step_pulse), 32'd0);
        check({tag, "_period"}, bus.period_cur, 32'd4);
    endtask

    initial begin
        int n;
        logic changed;
        int exp_space[8]  = '{4, 4, 3, 3, 2, 2, 2, 2};
        int exp_period[8] = '{4, 3, 3, 2, 2, 2, 2, 2};

        RST         = 1'b1;
        bus.start   = 1'b0;
        bus.jump    = 1'b0;
        bus.pause   = 1'b0;
        bus.rand_in = 8'h00;
        tick();
        check_reset("reset");
        RST = 1'b0;

        // Spawn and shift with rand_in=0: spawns on steps 1, 4, 7.
        pulse_start();
        check("start_state", 32'(bus.state), 32'd1);
        check("start_step", 32'(bus.step_pulse), 32'd0);
        wait_pulse(n);
        check("first_period", 32'(n + 1), 32'd4);
        tick();
        check("map_step1", 32'(bus.obstacle_map), 32'h80);
        step(); step(); step();
        check("map_step4", 32'(bus.obstacle_map), 32'h90);
        check("score_step4", 32'(bus.score), 32'd4);
        check("period_step4", bus.period_cur, 32'd2);
        step(); step(); step();
        check("map_step7", 32'(bus.obstacle_map), 32'h92);
        step();
        check("over_state", 32'(bus.state), 32'd3);
        check("over_score", 32'(bus.score), 32'd7);
        check("over_high", 32'(bus.high_score), 32'd7);
        check("over_no_step", 32'(bus.step_pulse), 32'd0);

        pulse_start();
        check("restart_state", 32'(bus.state), 32'd1);
        check("restart_map", 32'(bus.obstacle_map), 32'd0);
        check("restart_score", 32'(bus.score), 32'd0);
        check("restart_period", bus.period_cur, 32'd4);
        check("restart_high", 32'(bus.high_score), 32'd7);

        // Speed-up with no spawns; spacing must track period_cur.
        bus.rand_in = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            wait_pulse(n);
            check("step_spacing", 32'(n + 1), 32'(exp_space[i]));
            tick();
            check("period_after", bus.period_cur, 32'(exp_period[i]));
        end

        // Jump with obstacle in column 1 survives; second jump while airborne is ignored.
        bus.rand_in = 8'h00;
        step();
        bus.rand_in = 8'hFF;
        check("jmp1_spawn", 32'(bus.obstacle_map), 32'h80);
        for (int i = 0; i < 6; i++) step();
        check("jmp1_col1", 32'(bus.obstacle_map), 32'h02);
        pulse_jump();
        check("jmp1_air", 32'(bus.dino_air), 32'd1);
        step();
        check("jmp1_survive", 32'(bus.state), 32'd1);
        check("jmp1_air_s1", 32'(bus.dino_air), 32'd1);
        check("jmp1_map_s1", 32'(bus.obstacle_map), 32'h01);
        pulse_jump();
        step();
        check("jmp1_air_s2", 32'(bus.dino_air), 32'd0);
        check("jmp1_state_s2", 32'(bus.state), 32'd1);

        // Jump with obstacle in column 3 lands too early.
        bus.rand_in = 8'h00;
        step();
        bus.rand_in = 8'hFF;
        check("jmp3_spawn", 32'(bus.obstacle_map), 32'h80);
        for (int i = 0; i < 4; i++) step();
        check("jmp3_col3", 32'(bus.obstacle_map), 32'h08);
        pulse_jump();
        check("jmp3_air", 32'(bus.dino_air), 32'd1);
        step();
        check("jmp3_state_s1", 32'(bus.state), 32'd1);
        check("jmp3_air_s1", 32'(bus.dino_air), 32'd1);
        step();
        check("jmp3_state_s2", 32'(bus.state), 32'd1);
        check("jmp3_air_s2", 32'(bus.dino_air), 32'd0);
        step();
        check("jmp3_over", 32'(bus.state), 32'd3);
        check("jmp3_score", 32'(bus.score), 32'd24);
        check("jmp3_high", 32'(bus.high_score), 32'd24);

        // Pause with the tick counter frozen at 2.
        pulse_start();
        check("p_start", 32'(bus.state), 32'd1);
        tick();
        pulse_pause();
        check("p_state", 32'(bus.state), 32'd2);
        changed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.state !== 2'd2 || bus.obstacle_map !== 8'h00 || bus.dino_air !== 1'b0 ||
                bus.score !== 16'd0 || bus.high_score !== 16'd24 || bus.step_pulse !== 1'b0 ||
                bus.period_cur !== 32'd4) changed = 1'b1;
        end
        check("p_frozen", 32'(changed), 32'd0);
        pulse_pause();
        check("p_resume", 32'(bus.state), 32'd1);
        wait_pulse(n);
        check("p_resume_gap", 32'(n), 32'd1);
        tick();
        check("p_score", 32'(bus.score), 32'd1);

        // Pause and jump together: the jump is dropped.
        bus.pause = 1'b1;
        bus.jump  = 1'b1;
        tick();
        bus.pause = 1'b0;
        bus.jump  = 1'b0;
        check("pj_state", 32'(bus.state), 32'd2);
        check("pj_air", 32'(bus.dino_air), 32'd0);
        pulse_pause();
        check("pj_resume_air", 32'(bus.dino_air), 32'd0);

        // Pause on a step cycle: step completes, then paused.
        wait_pulse(n);
        pulse_pause();
        check("ps_state", 32'(bus.state), 32'd2);
        check("ps_score", 32'(bus.score), 32'd2);
        check("ps_period", bus.period_cur, 32'd3);

        // Asynchronous reset between clock edges.
        pulse_pause();
        tick();
        tick();
        #2 RST = 1'b1;
        #1 check_reset("async");
        RST = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
